data_sram_bridge: RTL and testbench

- Memory-side responder for the CPU's data SRAM-like port: enable, 4-bit byte write strobe, address, write data, read data and the ME-stage stall.
- Converts each single-access request into one transaction on a split address/data handshake bus (req/addr_ok/data_ok).
- Raises the core's data stall until the transaction completes, then holds the result until the whole pipeline advances.
- Sits between the core top and the bus arbiter/AXI shim.

---
 rtl/bus_pkg.sv | 17 +
 rtl/wen_to_size.sv | 45 ++++
 rtl/data_sram_bridge.sv | 158 +++++++++++++++
 tb/tb_data_sram_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the data SRAM-like to split-handshake bus bridge.
package bus_pkg;

    // Bridge transaction states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    // Bus transfer size codes.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/wen_to_size.sv
// Maps the core's byte write strobe onto a bus transfer size and the low
// address bits that locate the written lanes. Reads and full-word or
// unrecognised strobes become word-aligned word transfers.
module wen_to_size
    import bus_pkg::*;
(
    input  logic [3:0] wen,
    output logic [1:0] size,
    output logic [1:0] addr_lo,
    output logic       illegal
);

    // Decode strobe pattern into size and lane offset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        size    = SZ_WORD;
        addr_lo = 2'b00;
        illegal = 1'b0;
        case (wen)
            4'b0000, 4'b1111: begin
                size = SZ_WORD;
            end
            4'b0011: size = SZ_HALF;
            4'b1100: begin
                size    = SZ_HALF;
                addr_lo = 2'b10;
            end
            4'b0001: size = SZ_BYTE;
            4'b0010: begin
                size    = SZ_BYTE;
                addr_lo = 2'b01;
            end
            4'b0100: begin
                size    = SZ_BYTE;
                addr_lo = 2'b10;
            end
            4'b1000: begin
                size    = SZ_BYTE;
                addr_lo = 2'b11;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_sram_bridge.sv
// Data-side bridge: turns one CPU SRAM-like access into one req/addr_ok/data_ok
// bus transaction, stalls the core until it completes and holds the result
// until the pipeline advances. A flush during the transaction lets the bus
// side finish but drops the result.
module data_sram_bridge
    import bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter bit WRITE_WAIT_ACK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              longest_stall,
    input  logic              except_flush,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wr_q, mem_wr_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cancel_q, cancel_d;

    logic [1:0]          req_size;
    logic [1:0]          req_addr_lo;
    logic                req_illegal;
    logic                start;
    logic                complete;
    logic                addr_lo_unused;

    // The lane offset comes from the strobe, so the core's low address bits are not needed.
    assign addr_lo_unused = ^cpu_addr[1:0];

    assign start = (state_q == IDLE) & cpu_en & ~except_flush;

    wen_to_size u_wen_to_size (
        .wen     (cpu_wen),
        .size    (req_size),
        .addr_lo (req_addr_lo),
        .illegal (req_illegal)
    );

    // Next-state, request capture, completion and cancel bookkeeping.
    always_comb begin
        state_d     = state_q;
        mem_wr_d    = mem_wr_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        cancel_d    = cancel_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ADDR;
                    mem_wr_d    = |cpu_wen;
                    mem_wdata_d = cpu_wdata;
                    mem_size_d  = req_size;
                    mem_addr_d  = {cpu_addr[ADDR_W-1:2], req_addr_lo};
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok || (mem_wr_q && !WRITE_WAIT_ACK)) begin
                        complete = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    complete = 1'b1;
                end
            end
            DONE: begin
                if (!longest_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A flush while the bus is busy cannot drop req; remember it instead.
        if ((state_q == ADDR || state_q == DATA) && except_flush) begin
            cancel_d = 1'b1;
        end

        if (complete) begin
            cancel_d = 1'b0;
            if (cancel_q || except_flush) begin
                state_d = IDLE;
            end else begin
                state_d = DONE;
                if (!mem_wr_q) begin
                    cpu_rdata_d = mem_rdata;
                end
            end
        end

        mem_req_d = (state_d == ADDR);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            cancel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            cancel_q    <= cancel_d;
        end
    end

    assign cpu_stall = start | (state_q == ADDR) | (state_q == DATA);
    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_size  = mem_size_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;

    // Only the recognised strobe patterns may start a transaction.
    a_legal_strobe: assert property (@(posedge clk) disable iff (rst) start |-> !req_illegal);

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench: two bridges (write-acknowledge on data_ok and on
// addr_ok) share all inputs; a transaction-level model predicts both.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        longest_stall;
    logic        except_flush;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic [1:0]  cpu_stall_o;
    logic [1:0]  mem_req_o;
    logic [1:0]  mem_wr_o;
    logic [31:0] cpu_rdata_o [2];
    logic [1:0]  mem_size_o  [2];
    logic [31:0] mem_addr_o  [2];
    logic [31:0] mem_wdata_o [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;
    int req_cnt0 = 0;
    int base;

    always #5 clk = ~clk;

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32), .WRITE_WAIT_ACK(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_o[0]), .cpu_stall(cpu_stall_o[0]),
        .longest_stall(longest_stall), .except_flush(except_flush), .mem_req(mem_req_o[0]),
        .mem_wr(mem_wr_o[0]), .mem_size(mem_size_o[0]), .mem_addr(mem_addr_o[0]),
        .mem_wdata(mem_wdata_o[0]), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32), .WRITE_WAIT_ACK(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_o[1]), .cpu_stall(cpu_stall_o[1]),
        .longest_stall(longest_stall), .except_flush(except_flush), .mem_req(mem_req_o[1]),
        .mem_wr(mem_wr_o[1]), .mem_size(mem_size_o[1]), .mem_addr(mem_addr_o[1]),
        .mem_wdata(mem_wdata_o[1]), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // busy: a bus transaction is outstanding; acc: its address was taken;
    // hold: a result is being presented to the core until it advances.
    logic        m_busy [2], m_acc [2], m_hold [2], m_cancel [2], m_wr [2];
    logic [1:0]  m_size [2];
    logic [31:0] m_addr [2], m_wdata [2], m_rdata [2];
    logic        mf_fl, mf_dn;
    logic [1:0]  mf_sz, mf_lo;

    function automatic void strobe_shape(input logic [3:0] w, output logic [1:0] sz, output logic [1:0] lo);
        int ones;
        int low;
        ones = $countones(w);
        low  = 0;
        for (int b = 3; b >= 0; b--) if (w[b]) low = b;
        if (ones == 1) begin
            sz = 2'd0; lo = 2'(low);
        end else if (ones == 2 && (w == 4'b0011 || w == 4'b1100)) begin
            sz = 2'd1; lo = 2'(low);
        end else begin
            sz = 2'd2; lo = 2'd0;
        end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0; m_acc[i] <= 1'b0; m_hold[i] <= 1'b0; m_cancel[i] <= 1'b0;
                m_wr[i] <= 1'b0; m_size[i] <= 2'd0; m_addr[i] <= 32'd0; m_wdata[i] <= 32'd0;
                m_rdata[i] <= 32'd0;
            end else if (m_hold[i]) begin
                if (!longest_stall) m_hold[i] <= 1'b0;
            end else if (!m_busy[i]) begin
                if (cpu_en && !except_flush) begin
                    strobe_shape(cpu_wen, mf_sz, mf_lo);
                    m_busy[i]   <= 1'b1;
                    m_acc[i]    <= 1'b0;
                    m_cancel[i] <= 1'b0;
                    m_wr[i]     <= |cpu_wen;
                    m_wdata[i]  <= cpu_wdata;
                    m_size[i]   <= mf_sz;
                    m_addr[i]   <= {cpu_addr[31:2], mf_lo};
                end
            end else begin
                mf_fl = m_cancel[i] || except_flush;
                mf_dn = 1'b0;
                if (!m_acc[i]) begin
                    if (mem_addr_ok) begin
                        m_acc[i] <= 1'b1;
                        mf_dn = mem_data_ok || (m_wr[i] && i == 1);
                    end
                end else begin
                    mf_dn = mem_data_ok;
                end
                if (mf_dn) begin
                    m_busy[i]   <= 1'b0;
                    m_cancel[i] <= 1'b0;
                    if (!mf_fl) begin
                        m_hold[i] <= 1'b1;
                        if (!m_wr[i]) m_rdata[i] <= mem_rdata;
                    end
                end else begin
                    m_cancel[i] <= mf_fl;
                end
            end
        end
    end

    // Compare both bridges against the model mid-cycle.
    always @(negedge clk) begin
        if (mem_req_o[0] === 1'b1) req_cnt0++;
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("mem_req%0d", i), 32'(mem_req_o[i]), 32'(m_busy[i] && !m_acc[i]));
                check($sformatf("cpu_stall%0d", i), 32'(cpu_stall_o[i]),
                      32'(m_busy[i] || (!m_hold[i] && cpu_en && !except_flush)));
                check($sformatf("mem_wr%0d", i), 32'(mem_wr_o[i]), 32'(m_wr[i]));
                check($sformatf("mem_size%0d", i), 32'(mem_size_o[i]), 32'(m_size[i]));
                check($sformatf("mem_addr%0d", i), mem_addr_o[i], m_addr[i]);
                check($sformatf("mem_wdata%0d", i), mem_wdata_o[i], m_wdata[i]);
                check($sformatf("cpu_rdata%0d", i), cpu_rdata_o[i], m_rdata[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_en = 1'b0; cpu_wen = 4'b0000; except_flush = 1'b0; longest_stall = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    logic [3:0] legal_wen [10] = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    initial begin
        rst = 1'b1; cpu_addr = 32'd0; cpu_wdata = 32'd0; mem_rdata = 32'd0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_req", 32'(mem_req_o[0]), 32'd0);
        check("reset_stall", 32'(cpu_stall_o[0]), 32'd0);
        check("reset_rdata", cpu_rdata_o[0], 32'd0);
        check("reset_addr", mem_addr_o[1], 32'd0);
        chk_on = 1'b1;

        // Zero-wait read.
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1000_0006; longest_stall = 1'b1;
        #1 check("rd_c0_stall", 32'(cpu_stall_o[0]), 32'd1);
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1 check("rd_c1_req", 32'(mem_req_o[0]), 32'd1);
        check("rd_c1_addr", mem_addr_o[0], 32'h1000_0004);
        check("rd_c1_model_addr", m_addr[0], 32'h1000_0004);
        check("rd_c1_size", 32'(mem_size_o[0]), 32'd2);
        check("rd_c1_stall", 32'(cpu_stall_o[0]), 32'd1);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; longest_stall = 1'b0;
        #1 check("rd_c2_rdata", cpu_rdata_o[0], 32'hDEAD_BEEF);
        check("rd_c2_stall", 32'(cpu_stall_o[0]), 32'd0);
        tick(); idle();

        // Byte store with delayed addr_ok and data_ok; instance 1 finishes on addr_ok.
        tick();
        cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h20; cpu_wdata = 32'h00AA_0000; longest_stall = 1'b1;
        #1 check("st_c0_stall1", 32'(cpu_stall_o[1]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            mem_addr_ok = (c == 3);
            #1 check("st_req0", 32'(mem_req_o[0]), 32'd1);
            check("st_req1", 32'(mem_req_o[1]), 32'd1);
            if (c == 1) begin
                check("st_size", 32'(mem_size_o[0]), 32'd0);
                check("st_addr", mem_addr_o[0], 32'h22);
                check("st_wr", 32'(mem_wr_o[0]), 32'd1);
            end
        end
        tick();
        mem_addr_ok = 1'b0;
        #1 check("st_c4_req0", 32'(mem_req_o[0]), 32'd0);
        check("st_c4_stall0", 32'(cpu_stall_o[0]), 32'd1);
        check("st_c4_stall1_done", 32'(cpu_stall_o[1]), 32'd0);
        tick();
        mem_data_ok = 1'b1;
        #1 check("st_c5_stall0", 32'(cpu_stall_o[0]), 32'd1);
        tick();
        mem_data_ok = 1'b0; longest_stall = 1'b0;
        #1 check("st_c6_stall0", 32'(cpu_stall_o[0]), 32'd0);
        check("st_rdata_kept", cpu_rdata_o[0], 32'hDEAD_BEEF);
        tick(); idle();

        // Result held under a long pipeline stall.
        tick();
        base = req_cnt0;
        cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h300; longest_stall = 1'b1;
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int k = 0; k < 4; k++) begin
            tick();
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = $urandom;
            #1 check("hold_rdata", cpu_rdata_o[0], 32'hCAFE_F00D);
            check("hold_stall", 32'(cpu_stall_o[0]), 32'd0);
        end
        tick();
        longest_stall = 1'b0;
        tick();
        longest_stall = 1'b1; cpu_addr = 32'h304;
        #1 check("hold_reissue_idle", 32'(cpu_stall_o[0]), 32'd1);
        check("hold_one_req", 32'(req_cnt0 - base), 32'd1);
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; longest_stall = 1'b0;
        tick(); idle();

        // Flush while waiting for data: result dropped.
        tick();
        cpu_en = 1'b1; cpu_addr = 32'h400; longest_stall = 1'b1;
        tick();
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0; except_flush = 1'b1; cpu_en = 1'b0;
        tick();
        except_flush = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_data_ok = 1'b0; cpu_en = 1'b1; cpu_addr = 32'h500;
        #1 check("fl_new_stall", 32'(cpu_stall_o[0]), 32'd1);
        check("fl_rdata_kept", cpu_rdata_o[0], 32'h0BAD_F00D);
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h55AA_55AA;
        #1 check("fl_new_req", 32'(mem_req_o[0]), 32'd1);
        check("fl_new_addr", mem_addr_o[0], 32'h500);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; longest_stall = 1'b0;
        #1 check("fl_new_rdata", cpu_rdata_o[0], 32'h55AA_55AA);
        tick(); idle();

        // Reset while the request is on the bus.
        tick();
        cpu_en = 1'b1; cpu_wen = 4'hF; cpu_addr = 32'h600; cpu_wdata = 32'h1357_9BDF; longest_stall = 1'b1;
        tick();
        rst = 1'b1;
        #1 check("rst_req_before", 32'(mem_req_o[0]), 32'd1);
        tick();
        rst = 1'b0; cpu_en = 1'b0; cpu_wen = 4'h0;
        #1 check("rst_req", 32'(mem_req_o[0]), 32'd0);
        check("rst_stall", 32'(cpu_stall_o[0]), 32'd0);
        check("rst_addr", mem_addr_o[0], 32'd0);
        check("rst_wdata", mem_wdata_o[0], 32'd0);
        check("rst_wr", 32'(mem_wr_o[0]), 32'd0);
        check("rst_rdata", cpu_rdata_o[0], 32'd0);
        tick(); idle();

        // Back-to-back loads.
        tick();
        base = req_cnt0;
        cpu_en = 1'b1; cpu_addr = 32'h40; longest_stall = 1'b1;
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hA0A0_A0A0;
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; longest_stall = 1'b0;
        #1 check("b2b_done_req", 32'(mem_req_o[0]), 32'd0);
        check("b2b_rdata0", cpu_rdata_o[0], 32'hA0A0_A0A0);
        tick();
        cpu_addr = 32'h44; longest_stall = 1'b1;
        #1 check("b2b_idle_req", 32'(mem_req_o[0]), 32'd0);
        check("b2b_idle_stall", 32'(cpu_stall_o[0]), 32'd1);
        tick();
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hB0B0_B0B0;
        #1 check("b2b_req2", 32'(mem_req_o[0]), 32'd1);
        check("b2b_addr2", mem_addr_o[0], 32'h44);
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; longest_stall = 1'b0;
        #1 check("b2b_rdata1", cpu_rdata_o[0], 32'hB0B0_B0B0);
        tick(); idle();
        #1 check("b2b_two_reqs", 32'(req_cnt0 - base), 32'd2);

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst           = ($urandom_range(0, 199) == 0);
            cpu_en        = $urandom_range(0, 1) == 1;
            cpu_wen       = legal_wen[$urandom_range(0, 9)];
            cpu_addr      = $urandom;
            cpu_wdata     = $urandom;
            longest_stall = $urandom_range(0, 1) == 1;
            except_flush  = ($urandom_range(0, 11) == 0);
            mem_addr_ok   = $urandom_range(0, 1) == 1;
            mem_data_ok   = ($urandom_range(0, 2) == 0);
            mem_rdata     = $urandom;
        end
        tick();
        rst = 1'b0; idle();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
